spike_rate_monitor: RTL

- Sits directly downstream of the current-based LIF neuron and consumes its 1-bit spike and 8-bit membrane state.
- Reduces the spike train to per-window statistics: spike count (rate), most recent inter-spike interval (ISI), peak membrane state and a burst flag.
- Each window's result is presented through a one-entry valid/ready output register, for readout or for a downstream neuron's input-current generator.

---
 rtl/lif_pkg.sv | 17 +
 rtl/spike_rate_monitor_sat_counter.sv | 28 ++
 rtl/spike_rate_monitor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared types and defaults for the LIF neuron datapath and its monitors.
// Holds the monitor FSM encoding, the membrane state width and default sizing.
package lif_pkg;

    localparam int LIF_STATE_W = 8;

    localparam int DEF_WINDOW_CYCLES = 256;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_ISI_W         = 8;
    localparam int DEF_BURST_THRESH  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } mon_state_e;

endpackage

// File: rtl/spike_rate_monitor_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports: clk, rst (async high), clr, load/load_val, inc -> q.
// Priority is clr over load over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (inc && !(&q)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor: per-window spike rate, last ISI, peak membrane state
// and burst flag, offered through a one-entry valid/ready result register.
// Ports: clk, rst (async high), en, spike_in, state_in, out_ready ->
//        out_valid, rate_out, isi_out, peak_out, burst_out, overrun (sticky).
module spike_rate_monitor
    import lif_pkg::*;
#(
    parameter int          WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int          CNT_W         = DEF_CNT_W,
    parameter int          ISI_W         = DEF_ISI_W,
    parameter int unsigned BURST_THRESH  = DEF_BURST_THRESH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   spike_in,
    input  logic [LIF_STATE_W-1:0] state_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [CNT_W-1:0]       rate_out,
    output logic [ISI_W-1:0]       isi_out,
    output logic [LIF_STATE_W-1:0] peak_out,
    output logic                   burst_out,
    output logic                   overrun
);

    localparam int WC_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW_CYCLES - 1);
    localparam int BW = (CNT_W > 32) ? CNT_W : 32;

    mon_state_e             state;
    logic [WC_W-1:0]        win_cnt;
    logic [LIF_STATE_W-1:0] peak;
    logic [ISI_W-1:0]       last_isi;
    logic                   seen;
    logic [CNT_W-1:0]       cnt_q;
    logic [ISI_W-1:0]       isi_q;

    logic                   counting;
    logic                   start;
    logic                   stop;
    logic                   close;

    logic [CNT_W-1:0]       res_rate;
    logic [ISI_W-1:0]       res_isi;
    logic [LIF_STATE_W-1:0] res_peak;
    logic                   res_burst;

    assign counting = (state == COUNT) && en;
    assign start    = (state == IDLE) && en;
    assign stop     = (state == COUNT) && !en;
    assign close    = counting && (win_cnt == WIN_LAST);

    // Spike count restarts at close; the closing cycle's spike is folded
    // into the offered result below rather than into the counter.
    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (start | stop | close),
        .load     (1'b0),
        .load_val ('0),
        .inc      (counting & spike_in),
        .q        (cnt_q)
    );

    // ISI timer runs across window boundaries; cleared only on FSM moves.
    sat_counter #(
        .W(ISI_W)
    ) u_isi (
        .clk      (clk),
        .rst      (rst),
        .clr      (start | stop),
        .load     (counting & spike_in),
        .load_val (ISI_W'(1)),
        .inc      (counting & ~spike_in),
        .q        (isi_q)
    );

    // Result as it stands including this cycle's sample.
    always_comb begin
        res_rate = cnt_q;
        if (spike_in && !(&cnt_q)) begin
            res_rate = cnt_q + CNT_W'(1);
        end
        res_isi = last_isi;
        if (spike_in && seen) begin
            res_isi = isi_q;
        end
        res_peak  = (state_in > peak) ? state_in : peak;
        res_burst = (BW'(res_rate) >= BW'(BURST_THRESH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (start) begin
            state <= COUNT;
        end else if (stop) begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt  <= '0;
            peak     <= '0;
            last_isi <= '0;
            seen     <= 1'b0;
        end else if (start || stop) begin
            win_cnt  <= '0;
            peak     <= '0;
            last_isi <= '0;
            seen     <= 1'b0;
        end else if (counting) begin
            win_cnt  <= close ? '0 : win_cnt + WC_W'(1);
            peak     <= close ? '0 : res_peak;
            last_isi <= res_isi;
            if (spike_in) begin
                seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            rate_out  <= '0;
            isi_out   <= '0;
            peak_out  <= '0;
            burst_out <= 1'b0;
            overrun   <= 1'b0;
        end else if (close) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                rate_out  <= res_rate;
                isi_out   <= res_isi;
                peak_out  <= res_peak;
                burst_out <= res_burst;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
